// File: rtl/gpio_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_ctrl
//   Parametrised GPIO controller sitting between the CPU peripheral bus and the
//   chip pads. Provides per-pin output data and direction, a synchronised input
//   readback, and rise/fall edge-detect interrupts with a W1C status register.
//
// Configuration macro:
//   GPIO_SETCLR_EN  when defined, adds write-only atomic DATA_SET (8),
//                   DATA_CLR (9) and DATA_TGL (10) registers. When undefined
//                   those addresses are reserved (read 0, writes ignored).
//
// Parameters:
//   WIDTH        number of GPIO pins / bus width (1..32)
//   SYNC_STAGES  input synchroniser depth (>=2)
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   en, wr, addr      bus select, write/read select, word register address
//   data_in           write data
//   data_out          registered read data (holds last read value)
//   rd_valid          1-cycle pulse marking a fresh data_out
//   gpio_in           asynchronous pad inputs
//   gpio_out, gpio_oe pad output values and output enables (1 = drive)
//   irq               registered level interrupt
//
// Bus handshake: there is no backpressure. Every cycle with en=1 at a rising
// edge is one complete access; a read (wr=0) returns its data on data_out with
// rd_valid=1 in the following cycle. Writes never raise rd_valid.
// ---------------------------------------------------------------------------
module gpio_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] ADDR_DATA_OUT = 4'd0;
  localparam logic [3:0] ADDR_DIR      = 4'd1;
  localparam logic [3:0] ADDR_DATA_IN  = 4'd2;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'd3;
  localparam logic [3:0] ADDR_IRQ_RISE = 4'd4;
  localparam logic [3:0] ADDR_IRQ_FALL = 4'd5;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'd6;
`ifdef GPIO_SETCLR_EN
  localparam logic [3:0] ADDR_DATA_SET = 4'd8;
  localparam logic [3:0] ADDR_DATA_CLR = 4'd9;
  localparam logic [3:0] ADDR_DATA_TGL = 4'd10;
`endif

  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_rise_q;
  logic [WIDTH-1:0] irq_fall_q;
  logic [WIDTH-1:0] irq_stat_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] stat_set;
  logic [WIDTH-1:0] stat_clr;
  logic [WIDTH-1:0] stat_next;
  logic [WIDTH-1:0] rd_mux;

  assign wr_acc = en && wr;
  assign rd_acc = en && !wr;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign rise     = sync & ~prev_q;
  assign fall     = ~sync & prev_q;
  assign stat_set = (rise & irq_rise_q) | (fall & irq_fall_q);
  assign stat_clr = (wr_acc && addr == ADDR_IRQ_STAT) ? data_in : '0;
  // A new event in the same cycle as its W1C clear must not be lost.
  assign stat_next = (irq_stat_q & ~stat_clr) | stat_set;

  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA_OUT: rd_mux = data_out_q;
      ADDR_DIR:      rd_mux = dir_q;
      ADDR_DATA_IN:  rd_mux = sync;
      ADDR_IRQ_EN:   rd_mux = irq_en_q;
      ADDR_IRQ_RISE: rd_mux = irq_rise_q;
      ADDR_IRQ_FALL: rd_mux = irq_fall_q;
      ADDR_IRQ_STAT: rd_mux = irq_stat_q;
      default:       rd_mux = '0;
    endcase
  end

  // Input synchroniser and edge history. History resets to 0, so a pin that is
  // high when reset releases is seen as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync;
    end
  end

  // Writable configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
    end else if (wr_acc) begin
      case (addr)
        ADDR_DATA_OUT: data_out_q <= data_in;
        ADDR_DIR:      dir_q      <= data_in;
        ADDR_IRQ_EN:   irq_en_q   <= data_in;
        ADDR_IRQ_RISE: irq_rise_q <= data_in;
        ADDR_IRQ_FALL: irq_fall_q <= data_in;
`ifdef GPIO_SETCLR_EN
        ADDR_DATA_SET: data_out_q <= data_out_q | data_in;
        ADDR_DATA_CLR: data_out_q <= data_out_q & ~data_in;
        ADDR_DATA_TGL: data_out_q <= data_out_q ^ data_in;
`endif
        default: ;
      endcase
    end
  end

  // Interrupt status and the registered interrupt line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat_q <= '0;
      irq        <= 1'b0;
    end else begin
      irq_stat_q <= stat_next;
      irq        <= |(irq_stat_q & irq_en_q);
    end
  end

  // Read return path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         wr;
  logic [3:0]   addr;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         rd_valid;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_setclr;

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks: entered at a negedge, each occupies exactly one bus cycle.
  task automatic bus_write(input logic [3:0] a, input logic [W-1:0] d);
    en = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [W-1:0] exp);
    en = 1'b1; wr = 1'b0; addr = a;
    exp_q.push_back(exp);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor / scoreboard: every rd_valid pulse pops one expected read value.
  always @(posedge clk) begin
    #1;
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        check("read_data", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; data_in = '0; gpio_in = '0;
    #12;
    check("reset_gpio_out", gpio_out, '0);
    check("reset_irq", {31'd0, irq}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic write/read
    bus_write(4'd0, 32'hA5A5_A5A5);
    bus_write(4'd1, 32'h0000_FFFF);
    check("gpio_out_write", gpio_out, 32'hA5A5_A5A5);
    check("gpio_oe_write", gpio_oe, 32'h0000_FFFF);
    bus_read(4'd0, 32'hA5A5_A5A5);
    @(negedge clk);
    check("rd_valid_one_cycle", {31'd0, rd_valid}, '0);
    check("data_out_holds", data_out, 32'hA5A5_A5A5);
    bus_read(4'd1, 32'h0000_FFFF);

    // en low: write must be ignored, no read pulse
    en = 1'b0; wr = 1'b1; addr = 4'd0; data_in = 32'hA5A5_A5A6;
    @(negedge clk);
    check("en_low_no_rd_valid", {31'd0, rd_valid}, '0);
    wr = 1'b0;
    check("en_low_gpio_out", gpio_out, 32'hA5A5_A5A5);

    // Write to a RO register must not raise rd_valid or change DATA_IN
    bus_write(4'd2, 32'hFFFF_FFFF);
    check("write_no_rd_valid", {31'd0, rd_valid}, '0);
    gpio_in = 32'h0000_0001;
    idle(3);
    bus_read(4'd2, 32'h0000_0001);
    bus_read(4'd7, 32'h0);
    bus_write(4'd11, 32'hFFFF_FFFF);
    bus_read(4'd11, 32'h0);

    // Rising edge on pin 3: status at SYNC_STAGES+1, irq at SYNC_STAGES+2
    bus_write(4'd4, 32'h0000_0008);
    bus_write(4'd3, 32'h0000_0008);
    bus_read(4'd6, 32'h0);
    gpio_in[3] = 1'b1;
    idle(2);
    bus_read(4'd6, 32'h0);            // sampled at edge 3, before the status update
    check("irq_not_yet", {31'd0, irq}, '0);
    bus_read(4'd6, 32'h0000_0008);    // sampled at edge 4
    check("irq_asserted", {31'd0, irq}, 32'd1);
    bus_write(4'd6, 32'h0000_0008);
    idle(1);
    check("irq_cleared", {31'd0, irq}, '0);
    bus_read(4'd6, 32'h0);

    // Edge arriving in the same cycle as its W1C: set wins
    gpio_in[3] = 1'b0;
    idle(4);
    gpio_in[3] = 1'b1;
    idle(2);
    bus_write(4'd6, 32'h0000_0008);
    bus_read(4'd6, 32'h0000_0008);
    bus_write(4'd6, 32'hFFFF_FFFF);
    bus_read(4'd6, 32'h0);
    idle(1);

    // Falling edge on pin 0 sets status even though IRQ_EN bit 0 is off
    bus_write(4'd5, 32'h0000_0001);
    gpio_in[0] = 1'b0;
    idle(5);
    bus_read(4'd6, 32'h0000_0001);
    check("fall_no_irq", {31'd0, irq}, '0);
    bus_write(4'd6, 32'h0000_0001);

    // Atomic set/clear/toggle (reserved when the feature is off)
    bus_write(4'd0, 32'h1234_5678);
    bus_write(4'd8, 32'h0000_000F);
    bus_write(4'd9, 32'h1000_0000);
    bus_write(4'd10, 32'h0000_0001);
`ifdef GPIO_SETCLR_EN
    exp_setclr = 32'h0234_567E;
`else
    exp_setclr = 32'h1234_5678;
`endif
    check("setclr_gpio_out", gpio_out, exp_setclr);
    bus_read(4'd8, 32'h0);
    bus_read(4'd0, exp_setclr);
    idle(2);

    // Asynchronous reset mid-cycle clears all outputs without a clock edge
    bus_write(4'd6, 32'hFFFF_FFFF);
    bus_read(4'd1, 32'h0000_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data_out", data_out, '0);
    check("async_rst_gpio_out", gpio_out, '0);
    check("async_rst_gpio_oe", gpio_oe, '0);
    check("async_rst_rd_valid", {31'd0, rd_valid}, '0);
    check("async_rst_irq", {31'd0, irq}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    gpio_in = '0;
    bus_read(4'd0, 32'h0);
    bus_read(4'd3, 32'h0);
    idle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
